hazard_flush_controller: RTL and testbench
==========================================

Name: hazard_flush_controller

Overview:
- Control-side counterpart of the ID/EX pipeline latch. It consumes the decoded ID-stage fields and the registered EX-stage fields.
- It generates the latch's flush input, plus the PC and IF/ID hold and flush controls.
- It handles three cases: load-use stalls, control-transfer flushes, and a HALT drain/freeze sequence with debug resume.
- It sits beside the hazard/forwarding logic in the 5-stage MIPS datapath.

Parameters:
RNBITS, 5, register-index width
DRAIN_CYCLES, 3, bubble cycles after HALT detection before freezing (EX, MEM, WB drain)
CNTBITS, 16, width of stall statistics counter

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset_n  in  1  synchronous reset, active-low
i_ID_Rs  in  RNBITS  rs field of instruction in ID
i_ID_Rt  in  RNBITS  rt field of instruction in ID
i_ID_UsesRt  in  1  ID instruction reads rt as a source
i_ID_Halt  in  1  ID instruction is HALT
i_EX_MemRead  in  1  MemRead from ID/EX latch
i_EX_Rt  in  RNBITS  Rt from ID/EX latch
i_EX_TakeJump  in  1  branch taken / jump / JAL / JALR resolved in EX this cycle
i_Resume  in  1  debug resume request, sampled only in HALTED
o_PCWrite  out  1  PC load enable
o_IFID_Write  out  1  IF/ID load enable
o_IFID_Flush  out  1  clear IF/ID
o_IDEX_Flush  out  1  drives ID/EX i_Flush (bubble insert)
o_Halted  out  1  pipeline frozen
o_State  out  2  RUN=0, DRAIN=1, HALTED=2
o_StallCount  out  CNTBITS  saturating count of load-use bubble cycles

Behaviour:
- Registered state: FSM state, drain counter (ceil(log2(DRAIN_CYCLES+1)) bits), o_StallCount. All other outputs are combinational from state and inputs.
- Reset (i_reset_n=0 at a clock edge): state goes to RUN, drain counter to 0, o_StallCount to 0.
- Outputs while i_reset_n=0, regardless of state: o_PCWrite=0, o_IFID_Write=0, o_IFID_Flush=1, o_IDEX_Flush=1, o_Halted=0. This clears the reset-less latches.
- A reset asserted mid-DRAIN or in HALTED returns the block to RUN on the next edge.
- Load-use hazard (loaduse): i_EX_MemRead=1 and i_EX_Rt!=0 and (i_EX_Rt==i_ID_Rs or (i_ID_UsesRt and i_EX_Rt==i_ID_Rt)).
- RUN defaults: PCWrite=1, IFID_Write=1, both flushes 0, Halted=0.
- RUN priority 1, i_EX_TakeJump=1: IFID_Flush=1, IDEX_Flush=1, PCWrite=1, IFID_Write=1 (PC takes the target). Overrides loaduse and Halt. State stays RUN.
- RUN priority 2, loaduse: PCWrite=0, IFID_Write=0, IDEX_Flush=1 (one bubble). o_StallCount increments, saturating at all-ones. State stays RUN. The hazard clears the next cycle because the load has advanced.
- RUN priority 3, i_ID_Halt=1: PCWrite=0, IFID_Write=0, IDEX_Flush=1. Drain counter loads DRAIN_CYCLES. State goes to DRAIN.
- DRAIN: PCWrite=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0. Counter decrements each cycle. When the counter is 1 (last cycle), the next state is HALTED.
- In DRAIN, i_EX_TakeJump and loaduse are ignored; EX holds only bubbles.
- DRAIN_CYCLES=0 is illegal.
- HALTED: PCWrite=0, IFID_Write=0, IDEX_Flush=1, Halted=1.
- HALTED with i_Resume=1: outputs this cycle are PCWrite=1, IFID_Write=1, IDEX_Flush=1, Halted=1. Next state is RUN.
- Effect of resume: HALT in IF/ID is overwritten by the instruction at PC (HALT+4), and the HALT itself never enters EX.
- i_Resume outside HALTED has no effect.
- Invariant: o_PCWrite and o_IFID_Write are always equal.
- Invariant: o_IFID_Flush=1 only on a taken transfer in RUN, or during reset.

Test Plan:
1. Reset: hold i_reset_n=0 two cycles with random inputs -> IFID_Flush=IDEX_Flush=1, PCWrite=0, State=0, StallCount=0. Release -> PCWrite=1, flushes 0.
2. Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8 for one cycle -> PCWrite=0, IFID_Write=0, IDEX_Flush=1 that cycle only, StallCount 0->1.
3. Load-use negatives: EX_Rt=0 with ID_Rs=0 -> no stall. EX_Rt=9, ID_Rt=9, UsesRt=0 -> no stall. UsesRt=1 -> stall, StallCount +1.
4. Jump priority: TakeJump=1 together with a loaduse match and ID_Halt=1 -> IFID_Flush=1, IDEX_Flush=1, PCWrite=1. StallCount unchanged, State stays 0.
5. Halt/resume: ID_Halt=1 -> State 1 for 3 cycles with PCWrite=0 and IDEX_Flush=1, then State 2 with Halted=1. Hold 5 cycles frozen. Pulse i_Resume -> PCWrite=1 for that cycle, next State=0. Also assert TakeJump during DRAIN -> no IFID_Flush.
6. Saturation and mid-op reset: force 65535 load-use stalls, one more -> StallCount stays 0xFFFF. Reset during DRAIN cycle 2 -> State=0 after the edge, counter 0.

Source files
------------

// File: rtl/hazard_flush_controller.sv
// ID/EX control-side hazard unit: load-use bubbles, transfer flushes,
// and the HALT drain/freeze/resume sequence.
module hazard_flush_controller #(
   parameter int RNBITS       = 5,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNTBITS      = 16
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [RNBITS-1:0]  i_ID_Rs,
   input  logic [RNBITS-1:0]  i_ID_Rt,
   input  logic               i_ID_UsesRt,
   input  logic               i_ID_Halt,
   input  logic               i_EX_MemRead,
   input  logic [RNBITS-1:0]  i_EX_Rt,
   input  logic               i_EX_TakeJump,
   input  logic               i_Resume,
   output logic               o_PCWrite,
   output logic               o_IFID_Write,
   output logic               o_IFID_Flush,
   output logic               o_IDEX_Flush,
   output logic               o_Halted,
   output logic [1:0]         o_State,
   output logic [CNTBITS-1:0] o_StallCount
);

   // DRAIN_CYCLES must be at least 1.
   localparam int DBITS = $clog2(DRAIN_CYCLES + 1);

   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_DRAIN  = 2'd1;
   localparam logic [1:0] S_HALTED = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [DBITS-1:0] drain_cnt, drain_nxt;
   logic             load_use;
   logic             stall_inc;
   logic             pc_write;

   assign load_use = i_EX_MemRead && (i_EX_Rt != '0) &&
                     ((i_EX_Rt == i_ID_Rs) ||
                      (i_ID_UsesRt && (i_EX_Rt == i_ID_Rt)));

   always_comb begin
      pc_write     = 1'b1;
      o_IFID_Flush = 1'b0;
      o_IDEX_Flush = 1'b0;
      o_Halted     = 1'b0;
      state_nxt    = state;
      drain_nxt    = drain_cnt;
      stall_inc    = 1'b0;
      unique case (state)
         S_RUN: begin
            if (i_EX_TakeJump) begin
               o_IFID_Flush = 1'b1;
               o_IDEX_Flush = 1'b1;
            end else if (load_use) begin
               pc_write     = 1'b0;
               o_IDEX_Flush = 1'b1;
               stall_inc    = 1'b1;
            end else if (i_ID_Halt) begin
               pc_write     = 1'b0;
               o_IDEX_Flush = 1'b1;
               drain_nxt    = DBITS'(DRAIN_CYCLES);
               state_nxt    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            pc_write     = 1'b0;
            o_IDEX_Flush = 1'b1;
            drain_nxt    = drain_cnt - 1'b1;
            if (drain_cnt <= DBITS'(1))
               state_nxt = S_HALTED;
         end
         S_HALTED: begin
            // Resume reloads IF/ID over the HALT while EX keeps a bubble.
            pc_write     = i_Resume;
            o_IDEX_Flush = 1'b1;
            o_Halted     = 1'b1;
            if (i_Resume)
               state_nxt = S_RUN;
         end
         default: begin
            pc_write     = 1'b0;
            o_IDEX_Flush = 1'b1;
            state_nxt    = S_RUN;
         end
      endcase
      // Reset-less pipeline latches are cleared while reset is held.
      if (!i_reset_n) begin
         pc_write     = 1'b0;
         o_IFID_Flush = 1'b1;
         o_IDEX_Flush = 1'b1;
         o_Halted     = 1'b0;
      end
   end

   assign o_PCWrite    = pc_write;
   assign o_IFID_Write = pc_write;
   assign o_State      = state;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state        <= S_RUN;
         drain_cnt    <= '0;
         o_StallCount <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_nxt;
         if (stall_inc && (o_StallCount != '1))
            o_StallCount <= o_StallCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Directed bench for hazard_flush_controller with a per-cycle
// behavioural model and literal spot checks.
module tb_hazard_flush_controller;

   localparam int DRAIN = 3;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_rt;
   logic        id_uses_rt, id_halt, ex_memread, ex_jump, resume;
   logic        pc_write, ifid_write, ifid_flush, idex_flush, halted;
   logic [1:0]  state;
   logic [15:0] stall_count;

   hazard_flush_controller #(
      .RNBITS(5), .DRAIN_CYCLES(DRAIN), .CNTBITS(16)
   ) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_ID_Rs(id_rs), .i_ID_Rt(id_rt), .i_ID_UsesRt(id_uses_rt),
      .i_ID_Halt(id_halt), .i_EX_MemRead(ex_memread), .i_EX_Rt(ex_rt),
      .i_EX_TakeJump(ex_jump), .i_Resume(resume),
      .o_PCWrite(pc_write), .o_IFID_Write(ifid_write),
      .o_IFID_Flush(ifid_flush), .o_IDEX_Flush(idex_flush),
      .o_Halted(halted), .o_State(state), .o_StallCount(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else begin
         n_fail++;
         if (n_fail <= 20)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: mode 0=run 1=drain 2=halted; stalls kept unbounded.
   int m_mode   = 0;
   int m_left   = 0;
   int m_stalls = 0;

   function automatic bit hazard();
      if (!ex_memread || ex_rt == 0) return 1'b0;
      if (ex_rt == id_rs) return 1'b1;
      return id_uses_rt && (ex_rt == id_rt);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode = 0; m_left = 0; m_stalls = 0;
      end else if (m_mode == 0) begin
         if (ex_jump) ;
         else if (hazard()) m_stalls++;
         else if (id_halt) begin m_mode = 1; m_left = DRAIN; end
      end else if (m_mode == 1) begin
         m_left--;
         if (m_left == 0) m_mode = 2;
      end else if (resume) m_mode = 0;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         bit e_pc, e_fif, e_fex, e_h;
         e_pc = 1; e_fif = 0; e_fex = 0; e_h = 0;
         if (!rst_n) begin
            e_pc = 0; e_fif = 1; e_fex = 1;
         end else if (m_mode == 0) begin
            if (ex_jump) begin e_fif = 1; e_fex = 1; end
            else if (hazard() || id_halt) begin e_pc = 0; e_fex = 1; end
         end else if (m_mode == 1) begin
            e_pc = 0; e_fex = 1;
         end else begin
            e_pc = resume; e_fex = 1; e_h = 1;
         end
         chk("PCWrite", 32'(pc_write), 32'(e_pc));
         chk("IFID_Write", 32'(ifid_write), 32'(e_pc));
         chk("IFID_Flush", 32'(ifid_flush), 32'(e_fif));
         chk("IDEX_Flush", 32'(idex_flush), 32'(e_fex));
         chk("Halted", 32'(halted), 32'(e_h));
         chk("State", 32'(state), 32'(m_mode));
         chk("StallCount", 32'(stall_count),
             (m_stalls > 65535) ? 32'd65535 : 32'(m_stalls));
      end
   end

   task automatic idle();
      id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0;
      id_halt = 0; ex_memread = 0; ex_jump = 0; resume = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_in();
      id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rt = 5'($urandom);
      id_uses_rt = 1'($urandom); id_halt = 1'($urandom);
      ex_memread = 1'($urandom); ex_jump = 1'($urandom);
      resume = 1'($urandom);
   endtask

   initial begin
      rst_n = 1'b0;
      rand_in();
      chk_on = 1'b1;
      // reset held two cycles
      @(negedge clk);
      chk("lit_rst_pc", 32'(pc_write), 0);
      chk("lit_rst_fif", 32'(ifid_flush), 1);
      chk("lit_rst_fex", 32'(idex_flush), 1);
      chk("lit_rst_state", 32'(state), 0);
      chk("lit_rst_cnt", 32'(stall_count), 0);
      tick(); rand_in();
      tick(); idle(); rst_n = 1'b1;
      @(negedge clk);
      chk("lit_rel_pc", 32'(pc_write), 1);
      chk("lit_rel_fif", 32'(ifid_flush), 0);
      chk("lit_rel_fex", 32'(idex_flush), 0);
      // load-use on rs
      tick(); ex_memread = 1; ex_rt = 8; id_rs = 8;
      @(negedge clk);
      chk("lit_lu_pc", 32'(pc_write), 0);
      chk("lit_lu_ifw", 32'(ifid_write), 0);
      chk("lit_lu_fex", 32'(idex_flush), 1);
      tick(); idle();
      @(negedge clk);
      chk("lit_lu_cnt", 32'(stall_count), 1);
      chk("lit_lu_clear", 32'(pc_write), 1);
      // negatives, then rt hit
      tick(); ex_memread = 1; ex_rt = 0; id_rs = 0;
      @(negedge clk);
      chk("lit_r0_pc", 32'(pc_write), 1);
      tick(); ex_rt = 9; id_rt = 9; id_rs = 3; id_uses_rt = 0;
      @(negedge clk);
      chk("lit_nouse_pc", 32'(pc_write), 1);
      tick(); id_uses_rt = 1;
      @(negedge clk);
      chk("lit_use_pc", 32'(pc_write), 0);
      tick(); idle(); resume = 1;
      @(negedge clk);
      chk("lit_use_cnt", 32'(stall_count), 2);
      // jump beats load-use and halt
      tick(); resume = 0; ex_jump = 1; ex_memread = 1; ex_rt = 4;
      id_rs = 4; id_halt = 1;
      @(negedge clk);
      chk("lit_j_fif", 32'(ifid_flush), 1);
      chk("lit_j_fex", 32'(idex_flush), 1);
      chk("lit_j_pc", 32'(pc_write), 1);
      tick(); idle();
      @(negedge clk);
      chk("lit_j_cnt", 32'(stall_count), 2);
      chk("lit_j_state", 32'(state), 0);
      // halt, drain, freeze, resume
      tick(); id_halt = 1;
      @(negedge clk);
      chk("lit_h_pc", 32'(pc_write), 0);
      for (int i = 0; i < DRAIN; i++) begin
         tick();
         ex_jump = (i == 1);
         @(negedge clk);
         chk("lit_drain_state", 32'(state), 1);
         chk("lit_drain_fif", 32'(ifid_flush), 0);
      end
      for (int i = 0; i < 5; i++) begin
         tick(); ex_jump = 0;
         @(negedge clk);
         chk("lit_halted", 32'(halted), 1);
         chk("lit_halted_pc", 32'(pc_write), 0);
      end
      tick(); resume = 1;
      @(negedge clk);
      chk("lit_res_pc", 32'(pc_write), 1);
      chk("lit_res_fex", 32'(idex_flush), 1);
      tick(); idle();
      @(negedge clk);
      chk("lit_res_state", 32'(state), 0);
      // saturation
      tick(); ex_memread = 1; ex_rt = 5; id_rs = 5;
      for (int i = 0; i < 65540; i++) tick();
      @(negedge clk);
      chk("lit_sat", 32'(stall_count), 32'hFFFF);
      tick();
      @(negedge clk);
      chk("lit_sat2", 32'(stall_count), 32'hFFFF);
      // reset in drain cycle 2
      tick(); idle(); id_halt = 1;
      tick();
      tick(); rst_n = 0;
      @(negedge clk);
      chk("lit_mr_fif", 32'(ifid_flush), 1);
      tick(); rst_n = 1; idle();
      @(negedge clk);
      chk("lit_mr_state", 32'(state), 0);
      chk("lit_mr_cnt", 32'(stall_count), 0);
      // full drain length again after reset
      tick(); id_halt = 1;
      for (int i = 0; i < DRAIN + 1; i++) tick();
      @(negedge clk);
      chk("lit_redrain", 32'(state), 2);
      tick(); idle();
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
